mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter WIDTH, default 32, datapath and PC width in bits.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 Op  input  6  instruction opcode field, Instr[31:26].
REQ-005 Funct  input  6  R-type function field, Instr[5:0].
REQ-006 Instr  input  26  jump target field, Instr[25:0].
REQ-007 PC  input  WIDTH  current PC value from the PC register.
REQ-008 Zero  input  1  ALU zero flag for the current cycle.
REQ-009 ALUResult  input  WIDTH  combinational ALU output for the current cycle.
REQ-010 ALUOut  input  WIDTH  registered ALU output from the previous cycle.
REQ-011 PCC  output  WIDTH  next-PC value presented to the PC register.
REQ-012 PCEn  output  1  PC register write enable.
REQ-013 IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-014 ALUSrcB  output  2  ALU B-operand select: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-015 ALUControl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-016 State  output  4  current FSM state, for debug.

Function
REQ-017 Moore FSM; all controls except PCEn and PCC are decoded from the registered state only.
REQ-018 States and transitions: FETCH->DECODE; DECODE->MEMADR (lw 100011, sw 101011), EXECUTE (000000), BRANCH (000100), ADDIEXEC (001000), JUMP (000010), FETCH (any other opcode); MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-019 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU add, PCSrc=00, PCWrite=1.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ALU add (branch target precompute).
REQ-021 MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALU add. MEMRD: IorD=1. MEMWR: IorD=1, MemWrite=1.
REQ-022 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
REQ-023 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct; unknown Funct gives 010.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU sub, PCSrc=01, Branch=1. JUMP: PCSrc=10, PCWrite=1.
REQ-025 Every control not listed for a state is 0.
REQ-026 PCEn = PCWrite OR (Branch AND Zero), combinational, same cycle.
REQ-027 PCC by PCSrc: 00 -> ALUResult; 01 -> ALUOut; 10 -> {PC[WIDTH-1:WIDTH-4], Instr, 2'b00}; 11 -> ALUResult.
REQ-028 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
REQ-029 BRANCH with Zero=0 leaves PCEn=0; PCC value is don't-care but still ALUOut.

Reset
REQ-030 On a rising CLK edge with rst=1, the state register SHALL load FETCH, regardless of current state (mid-instruction included).
REQ-031 While rst=1, PCEn, IRWrite, MemWrite and RegWrite SHALL be forced 0 combinationally; the other outputs follow the state decode.
REQ-032 After rst deasserts, the first cycle is FETCH with PCEn=1.

Structure
REQ-033 Package mc_pkg holds the state encoding, the opcode constants, the Funct constants, and the ALUControl/ALUOp codes.
REQ-034 One sub-module, mc_alu_decoder, maps ALUOp (00 add, 01 sub, 10 funct) and Funct to ALUControl.

Verification
REQ-035 rst=1 for 2 cycles, then 0 with Op=100011 -> State FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 only in MEMWB; PCEn=1 only in FETCH.
REQ-036 Op=000100, Zero=1 in BRANCH, ALUOut=0x40 -> PCEn=1, PCC=0x40; repeat with Zero=0 -> PCEn=0.
REQ-037 Op=000010, PC=0xA0000010, Instr=0x0000100 -> in JUMP, PCEn=1, PCC=0xA0000400.
REQ-038 R-type with Funct 100000/100010/100100/100101/101010/111111 -> ALUControl in EXECUTE 010/110/000/001/111/010.
REQ-039 Op=111111 -> FETCH, DECODE, FETCH; no RegWrite or MemWrite pulse.
REQ-040 rst=1 asserted in MEMRD -> PCEn, MemWrite and RegWrite are 0 immediately; State is FETCH after the next edge.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// R-type function codes and ALU control codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle. The master side is the controller (reads
// instruction/ALU status, drives controls); the slave side is the datapath.
interface mc_controller_if #(parameter int WIDTH = 32);
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic [25:0]      Instr;
    logic [WIDTH-1:0] PC;
    logic             Zero;
    logic [WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0] ALUOut;
    logic [WIDTH-1:0] PCC;
    logic             PCEn;
    logic             IorD;
    logic             IRWrite;
    logic             MemWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic [3:0]       State;

    modport master (
        input  Op, Funct, Instr, PC, Zero, ALUResult, ALUOut,
        output PCC, PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUControl, State
    );

    modport slave (
        output Op, Funct, Instr, PC, Zero, ALUResult, ALUOut,
        input  PCC, PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUControl, State
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's ALUOp class plus the R-type Funct field to an ALU operation.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Select the ALU operation; unknown Funct falls back to add.
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller: Moore FSM decoding datapath controls
// from the registered state, plus the PC enable and next-PC mux.
module mc_controller
    import mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             rst,
    mc_controller_if.master  bus
);

    state_t state, next_state;
    aluop_t aluop;
    pcsrc_t pcsrc;
    logic   pcwrite, branch, irwrite, memwrite, regwrite;

    // State register; reset is synchronous and may interrupt any instruction.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // Next-state selection from the current state and opcode.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    next_state = S_MEMWB;
            S_EXECUTE:  next_state = S_ALUWB;
            S_ADDIEXEC: next_state = S_ADDIWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Moore control decode; anything not named for a state stays 0.
    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        pcsrc        = PCSRC_ALU;
        aluop        = ALUOP_ADD;
        irwrite      = 1'b0;
        memwrite     = 1'b0;
        regwrite     = 1'b0;
        bus.IorD     = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        case (state)
            S_FETCH: begin
                irwrite     = 1'b1;
                bus.ALUSrcB = 2'b01;
                pcwrite     = 1'b1;
            end
            S_DECODE:   bus.ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEMRD:    bus.IorD = 1'b1;
            S_MEMWR: begin
                bus.IorD = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                regwrite     = 1'b1;
            end
            S_ALUWB: begin
                bus.RegDst = 1'b1;
                regwrite   = 1'b1;
            end
            S_ADDIWB:   regwrite = 1'b1;
            S_EXECUTE: begin
                bus.ALUSrcA = 1'b1;
                aluop       = ALUOP_FUNCT;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                aluop       = ALUOP_SUB;
                pcsrc       = PCSRC_ALUOUT;
                branch      = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-PC mux from the decoded PC source.
    always_comb begin
        case (pcsrc)
            PCSRC_ALUOUT: bus.PCC = bus.ALUOut;
            PCSRC_JUMP:   bus.PCC = {bus.PC[WIDTH-1 -: 4], bus.Instr, 2'b00};
            default:      bus.PCC = bus.ALUResult;
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (bus.Funct),
        .alu_control (bus.ALUControl)
    );

    // Write strobes are masked by reset without waiting for the edge.
    assign bus.PCEn     = ~rst & (pcwrite | (branch & bus.Zero));
    assign bus.IRWrite  = ~rst & irwrite;
    assign bus.MemWrite = ~rst & memwrite;
    assign bus.RegWrite = ~rst & regwrite;
    assign bus.State    = state;

endmodule
